// File: rtl/sysbus_arbiter.sv
// Two-requester round-robin arbiter in front of a single Sysbus port.
// One transaction in flight: address phase, then write data or read response beats.
module sysbus_arbiter #(
    parameter int BEATS = 8,
    parameter int TAGW  = 13
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      m_reqcyc,
    input  logic [63:0]     m_req [2],
    input  logic [TAGW-1:0] m_reqtag [2],
    output logic [1:0]      m_reqack,
    output logic [1:0]      m_respcyc,
    output logic [63:0]     m_resp,
    output logic [TAGW-1:0] m_resptag,
    input  logic [1:0]      m_respack,
    output logic            bus_reqcyc,
    output logic [63:0]     bus_req,
    output logic [TAGW-1:0] bus_reqtag,
    input  logic            bus_reqack,
    input  logic            bus_respcyc,
    input  logic [63:0]     bus_resp,
    input  logic [TAGW-1:0] bus_resptag,
    output logic            bus_respack
);

    localparam int CW = $clog2(BEATS) + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, REQ, WDATA, RESP} state_t;

    state_t        r_state;
    logic          r_grant;
    logic          r_lastGrant;
    logic [CW-1:0] r_beatCnt;

    logic w_fwdReq;
    logic w_fwdResp;
    logic w_reqBeat;
    logic w_respBeat;
    logic w_nextGrant;

    assign w_fwdReq    = (r_state == REQ) || (r_state == WDATA);
    assign w_fwdResp   = (r_state == RESP);
    assign w_reqBeat   = m_reqcyc[r_grant] & bus_reqack;
    assign w_respBeat  = bus_respcyc & m_respack[r_grant];
    // A lone requester wins outright; under contention the previous loser wins.
    assign w_nextGrant = (&m_reqcyc) ? ~r_lastGrant : m_reqcyc[1];

    always_comb begin
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        m_reqack    = 2'b00;
        m_respcyc   = 2'b00;
        m_resp      = '0;
        m_resptag   = '0;
        bus_respack = 1'b0;
        if (w_fwdReq) begin
            bus_reqcyc          = m_reqcyc[r_grant];
            bus_req             = m_req[r_grant];
            bus_reqtag          = m_reqtag[r_grant];
            m_reqack[r_grant]   = bus_reqack;
        end
        if (w_fwdResp) begin
            m_respcyc[r_grant]  = bus_respcyc;
            m_resp              = bus_resp;
            m_resptag           = bus_resptag;
            bus_respack         = m_respack[r_grant];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_grant     <= 1'b0;
            r_lastGrant <= 1'b1;
            r_beatCnt   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_beatCnt <= '0;
                    if (|m_reqcyc) begin
                        r_grant     <= w_nextGrant;
                        r_lastGrant <= w_nextGrant;
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    if (w_reqBeat) begin
                        r_beatCnt <= '0;
                        r_state   <= m_reqtag[r_grant][TAGW-1] ? RESP : WDATA;
                    end
                end
                WDATA: begin
                    if (w_reqBeat) begin
                        r_beatCnt <= r_beatCnt + 1'b1;
                        if (r_beatCnt == LAST_BEAT) r_state <= IDLE;
                    end
                end
                RESP: begin
                    if (w_respBeat) begin
                        r_beatCnt <= r_beatCnt + 1'b1;
                        if (r_beatCnt == LAST_BEAT) r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Randomised bench for sysbus_arbiter: a transaction-level model checked every
// falling edge, plus directed scenarios with hand-computed expectations.
module tb_sysbus_arbiter;

    localparam int BEATS = 8;
    localparam int TAGW  = 13;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      m_reqcyc;
    logic [63:0]     m_req [2];
    logic [TAGW-1:0] m_reqtag [2];
    logic [1:0]      m_reqack;
    logic [1:0]      m_respcyc;
    logic [63:0]     m_resp;
    logic [TAGW-1:0] m_resptag;
    logic [1:0]      m_respack;
    logic            bus_reqcyc;
    logic [63:0]     bus_req;
    logic [TAGW-1:0] bus_reqtag;
    logic            bus_reqack;
    logic            bus_respcyc;
    logic [63:0]     bus_resp;
    logic [TAGW-1:0] bus_resptag;
    logic            bus_respack;

    int vectors     = 0;
    int miscompares = 0;

    sysbus_arbiter #(.BEATS(BEATS), .TAGW(TAGW)) dut (
        .clk(clk), .reset(reset),
        .m_reqcyc(m_reqcyc), .m_req(m_req), .m_reqtag(m_reqtag),
        .m_reqack(m_reqack), .m_respcyc(m_respcyc), .m_resp(m_resp),
        .m_resptag(m_resptag), .m_respack(m_respack),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
        .bus_resptag(bus_resptag), .bus_respack(bus_respack)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the bus, whether the address is still
    // pending, read or write, and how many beats remain.
    bit mBusy = 0;
    bit mAddrPending = 0;
    bit mRead = 0;
    int mWho = 0;
    int mPrev = 1;
    int mLeft = 0;

    always @(negedge clk) begin
        bit fwdReq, fwdResp;
        logic [1:0] expAck, expRespcyc;
        if (!reset) begin
            mBusy = 0;
            mAddrPending = 0;
            mPrev = 1;
        end
        fwdReq  = mBusy && (mAddrPending || !mRead);
        fwdResp = mBusy && !mAddrPending && mRead;
        expAck     = 2'b00;
        expRespcyc = 2'b00;
        if (fwdReq)  expAck[mWho]     = bus_reqack;
        if (fwdResp) expRespcyc[mWho] = bus_respcyc;
        checkOutput("bus_reqcyc",  64'(bus_reqcyc),  fwdReq ? 64'(m_reqcyc[mWho]) : 64'd0);
        checkOutput("bus_req",     bus_req,          fwdReq ? m_req[mWho] : 64'd0);
        checkOutput("bus_reqtag",  64'(bus_reqtag),  fwdReq ? 64'(m_reqtag[mWho]) : 64'd0);
        checkOutput("m_reqack",    64'(m_reqack),    64'(expAck));
        checkOutput("m_respcyc",   64'(m_respcyc),   64'(expRespcyc));
        checkOutput("m_resp",      m_resp,           fwdResp ? bus_resp : 64'd0);
        checkOutput("m_resptag",   64'(m_resptag),   fwdResp ? 64'(bus_resptag) : 64'd0);
        checkOutput("bus_respack", 64'(bus_respack), fwdResp ? 64'(m_respack[mWho]) : 64'd0);

        if (reset) begin
            if (!mBusy) begin
                if (m_reqcyc != 2'b00) begin
                    if (m_reqcyc == 2'b11) mWho = 1 - mPrev;
                    else mWho = m_reqcyc[0] ? 0 : 1;
                    mPrev = mWho;
                    mBusy = 1;
                    mAddrPending = 1;
                end
            end else if (mAddrPending) begin
                if (m_reqcyc[mWho] && bus_reqack) begin
                    mAddrPending = 0;
                    mRead = m_reqtag[mWho][TAGW-1];
                    mLeft = BEATS;
                end
            end else if (mRead ? (bus_respcyc && m_respack[mWho]) : (m_reqcyc[mWho] && bus_reqack)) begin
                mLeft--;
                if (mLeft == 0) mBusy = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        m_reqcyc    = 2'b00;
        m_req[0]    = '0;
        m_req[1]    = '0;
        m_reqtag[0] = '0;
        m_reqtag[1] = '0;
        m_respack   = 2'b11;
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp    = '0;
        bus_resptag = '0;
    endtask

    task automatic doReset();
        reset = 1'b0;
        idleInputs();
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    task automatic applyStimulus();
        m_reqcyc    = 2'($urandom_range(0, 3));
        m_req[0]    = {$urandom(), $urandom()};
        m_req[1]    = {$urandom(), $urandom()};
        m_reqtag[0] = TAGW'($urandom());
        m_reqtag[1] = TAGW'($urandom());
        m_respack   = 2'($urandom_range(0, 3)) | 2'($urandom_range(0, 3));
        bus_reqack  = ($urandom_range(0, 9) < 6);
        bus_respcyc = ($urandom_range(0, 9) < 7);
        bus_resp    = {$urandom(), $urandom()};
        bus_resptag = TAGW'($urandom());
    endtask

    localparam logic [TAGW-1:0] RD = {1'b1, 12'h05A};
    localparam logic [TAGW-1:0] WR = {1'b0, 12'h0C3};

    initial begin
        reset = 1'b0;
        idleInputs();
        #2;
        checkOutput("reset_bus_reqcyc", 64'(bus_reqcyc), 64'd0);
        checkOutput("reset_m_reqack", 64'(m_reqack), 64'd0);
        cyc();
        reset = 1'b1;
        cyc();

        // Single fetch read from requester 0
        m_reqcyc = 2'b01; m_req[0] = 64'h1000; m_reqtag[0] = RD;
        #1 checkOutput("rd_idle_no_reqcyc", 64'(bus_reqcyc), 64'd0);
        cyc();
        checkOutput("rd_reqcyc_n1", 64'(bus_reqcyc), 64'd1);
        checkOutput("rd_addr", bus_req, 64'h1000);
        checkOutput("rd_ack_wait", 64'(m_reqack), 64'd0);
        bus_reqack = 1'b1;
        #1 checkOutput("rd_ack", 64'(m_reqack), 64'b01);
        cyc();
        m_reqcyc = 2'b00; bus_reqack = 1'b0;
        for (int i = 1; i <= BEATS; i++) begin
            bus_respcyc = 1'b1; bus_resp = 64'(i * 16);
            #1 checkOutput("rd_respcyc", 64'(m_respcyc), 64'b01);
            checkOutput("rd_resp", m_resp, 64'(i * 16));
            cyc();
        end
        #1 checkOutput("rd_done_stray_respack", 64'(bus_respack), 64'd0);
        checkOutput("rd_done_stray_respcyc", 64'(m_respcyc), 64'd0);
        bus_respcyc = 1'b0;
        cyc();

        // Contention alternates 0,1,0,1 starting with requester 0
        doReset();
        m_reqcyc = 2'b11; m_reqtag[0] = RD; m_reqtag[1] = RD; bus_reqack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            checkOutput("rr_grant", 64'(m_reqack), (k % 2 == 0) ? 64'b01 : 64'b10);
            cyc();
            for (int b = 0; b < BEATS; b++) begin
                bus_respcyc = 1'b1;
                cyc();
            end
            bus_respcyc = 1'b0;
        end
        m_reqcyc = 2'b00;
        cyc();
        cyc();

        // Write from requester 1: address then eight data beats
        m_reqcyc = 2'b10; m_req[1] = 64'h2000; m_reqtag[1] = WR; bus_reqack = 1'b1;
        cyc();
        checkOutput("wr_addr", bus_req, 64'h2000);
        checkOutput("wr_ack", 64'(m_reqack), 64'b10);
        cyc();
        for (int i = 1; i <= BEATS; i++) begin
            m_req[1] = 64'(i);
            #1 checkOutput("wr_data", bus_req, 64'(i));
            cyc();
        end
        m_reqcyc = 2'b00;
        #1 checkOutput("wr_done_idle", 64'(bus_reqcyc), 64'd0);
        bus_reqack = 1'b0;
        cyc();

        // Read with three cycles of response backpressure
        m_reqcyc = 2'b01; m_req[0] = 64'h3000; m_reqtag[0] = RD; bus_reqack = 1'b1;
        cyc();
        cyc();
        m_reqcyc = 2'b00; bus_reqack = 1'b0;
        for (int c = 0; c < BEATS + 3; c++) begin
            bus_respcyc = 1'b1;
            m_respack = (c >= 2 && c < 5) ? 2'b00 : 2'b11;
            #1 checkOutput("bp_respack", 64'(bus_respack), (c >= 2 && c < 5) ? 64'd0 : 64'd1);
            checkOutput("bp_still_resp", 64'(m_respcyc), 64'b01);
            cyc();
        end
        m_respack = 2'b11;
        #1 checkOutput("bp_done", 64'(m_respcyc), 64'd0);
        bus_respcyc = 1'b0;
        cyc();

        // Reset asserted in the middle of a read response
        m_reqcyc = 2'b01; m_req[0] = 64'h4000; m_reqtag[0] = RD; bus_reqack = 1'b1;
        cyc();
        cyc();
        m_reqcyc = 2'b00; bus_reqack = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bus_respcyc = 1'b1;
            cyc();
        end
        #1 checkOutput("mid_resp_active", 64'(m_respcyc), 64'b01);
        reset = 1'b0;
        #1 checkOutput("async_rst_respcyc", 64'(m_respcyc), 64'd0);
        checkOutput("async_rst_respack", 64'(bus_respack), 64'd0);
        cyc();
        bus_respcyc = 1'b0;
        cyc();
        reset = 1'b1;
        m_reqcyc = 2'b10; m_req[1] = 64'h5000; m_reqtag[1] = RD; bus_reqack = 1'b1;
        cyc();
        checkOutput("post_rst_grant", 64'(m_reqack), 64'b10);
        checkOutput("post_rst_addr", bus_req, 64'h5000);

        // Randomised traffic with occasional asynchronous resets
        doReset();
        for (int n = 0; n < 4000; n++) begin
            applyStimulus();
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                cyc();
                reset = 1'b1;
            end else begin
                cyc();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sysbus_arbiter.md
SYSBUS_ARBITER -- requirements
Module: sysbus_arbiter

Interface
REQ-001 Parameter: BEATS, 8, number of 64-bit data beats in a line transfer (read response or write data).
REQ-002 Parameter: TAGW, 13, request/response tag width; tag bit [TAGW-1] is READ(1)/WRITE(0).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; asserted when 0.
REQ-005 m_reqcyc[1:0]  in  2  per-requester request valid; index 0 = instruction fetch, 1 = data.
REQ-006 m_req[0..1]  in  64 each  per-requester address (first beat) or write data (later beats).
REQ-007 m_reqtag[0..1]  in  TAGW each  per-requester request tag.
REQ-008 m_reqack[1:0]  out  2  per-requester request accepted.
REQ-009 m_respcyc[1:0]  out  2  per-requester response beat valid.
REQ-010 m_resp  out  64  response data, shared by both requesters.
REQ-011 m_resptag  out  TAGW  response tag, shared by both requesters.
REQ-012 m_respack[1:0]  in  2  per-requester response beat accepted.
REQ-013 bus_reqcyc, bus_req[63:0], bus_reqtag[TAGW-1:0]  out  downstream Sysbus request.
REQ-014 bus_reqack  in  1  downstream request accepted.
REQ-015 bus_respcyc, bus_resp[63:0], bus_resptag[TAGW-1:0]  in  downstream response.
REQ-016 bus_respack  out  1  downstream response accepted.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WDATA, RESP; exactly one transaction in flight.
REQ-018 IDLE: if any m_reqcyc is high, grant is registered and the FSM moves to REQ next cycle; no bus_reqcyc is driven in IDLE.
REQ-019 Arbitration SHALL be round-robin; with both requesting, grant goes to the requester not granted last; the first grant after reset goes to requester 0.
REQ-020 REQ: bus_reqcyc/bus_req/bus_reqtag SHALL equal the granted requester's signals combinationally; m_reqack[grant] = bus_reqack; other m_reqack = 0.
REQ-021 REQ with bus_reqack=1: READ tag -> RESP; WRITE tag -> WDATA with beat counter cleared.
REQ-022 WDATA: granted m_reqcyc/m_req forwarded to bus; each cycle with granted m_reqcyc=1 and bus_reqack=1 counts one beat; after BEATS beats -> IDLE; no response expected for writes.
REQ-023 RESP: m_respcyc[grant] = bus_respcyc, m_resp = bus_resp, m_resptag = bus_resptag, bus_respack = m_respack[grant]; non-granted m_respcyc = 0.
REQ-024 RESP: a beat is counted when bus_respcyc=1 and bus_respack=1; after BEATS counted beats -> IDLE.
REQ-025 Beat counter SHALL be $clog2(BEATS)+1 bits wide and never wrap within a transaction.
REQ-026 Outside REQ/WDATA, bus_reqcyc = 0 and m_reqack = 0; outside RESP, bus_respack = 0 and m_respcyc = 0.
REQ-027 bus_respcyc=1 outside RESP SHALL be ignored (bus_respack held 0) and shall not change state.
REQ-028 A requester dropping m_reqcyc in REQ before ack SHALL be held in REQ; the transaction is not abandoned.
REQ-029 Returning to IDLE and a new grant SHALL take one cycle (no same-cycle re-grant).
REQ-030 Minimum read latency: m_reqcyc high at cycle N -> bus_reqcyc high at N+1.

Reset
REQ-031 On reset=0 (asynchronous): state=IDLE, grant=0, last-grant=1 (so requester 0 wins first), beat counter=0.
REQ-032 During reset all outputs SHALL be 0; reset mid-transaction aborts it with no further acks or beats forwarded.

Verification
REQ-033 Single fetch read: m_reqcyc[0]=1, addr 0x1000, READ tag -> bus_reqcyc at N+1, bus_req=0x1000; 8 response beats routed only to m_respcyc[0]; IDLE after 8th beat.
REQ-034 Simultaneous requests after reset -> requester 0 granted first, requester 1 second; repeated contention alternates 0,1,0,1.
REQ-035 Data write: m_reqtag[1] WRITE, addr 0x2000, then 8 data beats 0x1..0x8 -> bus_req carries 0x2000 then 0x1..0x8; no response awaited; IDLE after beat 8.
REQ-036 Backpressure: m_respack[0]=0 for 3 cycles during read -> bus_respack=0 those cycles; beat count unaffected; total still 8.
REQ-037 Stray bus_respcyc=1 in IDLE -> bus_respack=0, m_respcyc=00, state IDLE.
REQ-038 reset=0 asserted mid-RESP after 3 beats -> outputs 0 immediately (asynchronously); after release, next request granted normally from IDLE.
